fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `sync_fifo` write port among `NUM_REQ` producers. Each producer holds a request plus data until acknowledged. The arbiter grants one producer at a time for a bounded burst of up to `MAX_BURST` words. It never issues a write while the FIFO reports `full`, so FIFO overflow cannot originate from this block. It sits directly in front of the `sync_fifo` write interface; the read side is untouched.

## Interface
- `NUM_REQ`, 4: number of producers, ≥2.
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `MAX_BURST`, 4: maximum consecutive accepted words per grant, ≥1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0); one clock; reset is asynchronous and active-low.
- `req`  in  NUM_REQ  per-producer request; held high with stable data until acked.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `fifo_full`  in  1  FIFO full flag.
- `ack`  out  NUM_REQ  one-hot pulse; the word of producer i is written this cycle.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_wr_data`  out  DATA_WIDTH  FIFO write data.
- `grant_valid`  out  1  an owner is currently granted.
- `grant_id`  out  $clog2(NUM_REQ)  current owner index.

## Operation
- State: `state` in {IDLE, GRANT}, `owner`, `burst_cnt` (0..MAX_BURST-1), `rr_last` (last owner).
- Reset values:
  - state=IDLE, owner=0, burst_cnt=0, rr_last=NUM_REQ-1, so the first search starts at index 0.
  - All outputs 0.
- Winner search: first i with req[i]=1, scanning rr_last+1, rr_last+2, … modulo NUM_REQ.
- Accept (combinational): accept = (state==GRANT) && req[owner] && !fifo_full.
  - fifo_wr_en = accept.
  - ack = accept ? (1<<owner) : 0.
- `fifo_wr_data` = req_data slice of `owner` whenever state==GRANT, else 0.
- `grant_valid` = (state==GRANT); `grant_id` = owner.
- IDLE:
  - any req → GRANT with owner=winner, burst_cnt=0.
  - none → stay IDLE.
- GRANT, release conditions:
  - (a) accept with burst_cnt==MAX_BURST-1;
  - (b) req[owner]==0.
- GRANT, on release:
  - rr_last=owner.
  - If the winner search (using the updated rr_last and current req; for (a) the owner is still eligible, but only when it is the sole requester) finds a requester → GRANT with the new owner, burst_cnt=0.
  - Otherwise → IDLE.
- GRANT, accept without release: burst_cnt+1.
- GRANT, fifo_full with req[owner]=1: hold owner and burst_cnt; no rotation and no ack.
- A producer dropping req without ack is legal (abort): treated as release (b), with no write.

## Timing
- Arbitration latency: a req rising in IDLE gets its first ack in the next cycle at the earliest.
- Owner handover: back-to-back, with no idle bubble between bursts when other requests are pending.
- Burst throughput: 1 word/cycle while req[owner]=1 and !fifo_full.
- `fifo_full` → `fifo_wr_en` path is combinational, same cycle. A full FIFO never sees wr_en=1 from this block.
- Simultaneous accept and release in one cycle: the write completes, and the new owner takes effect next cycle.
- `rst` asserted mid-burst: all state and outputs clear immediately (async). In-flight words not acked are not written. The first grant after deassert goes to the lowest requesting index.
- `rr_last` wrap: after owner NUM_REQ-1, the search starts at 0.

## Test plan
- Reset: rst=0 with req=4'b1111 → ack=0, fifo_wr_en=0, grant_valid=0. Release rst → grant_id=0 in cycle 1, with the first ack[0] the same cycle.
- Burst rotation: req=4'b1111 held, FIFO never full.
  - acks: 4×ack[0], 4×ack[1], 4×ack[2], 4×ack[3], then ack[0] again.
  - fifo_wr_en continuously 1 after the first grant.
  - fifo_wr_data matches the owner's slice.
- Sole requester: only req[2] high for 10 words → 10 consecutive acks[2], with a re-grant every 4 words and no bubble.
- Full backpressure: owner 1 mid-burst (burst_cnt=2), fifo_full=1 for 5 cycles.
  - fifo_wr_en=0 and ack=0 throughout, and grant_id stays 1.
  - After full drops: exactly 2 more ack[1], then handover.
- Abort: owner 3 drops req before its first ack while req[0]=1 → next cycle grant_id=0, no write from producer 3.
- Overflow guard with a real `sync_fifo` (DEPTH=16): 4 producers each push 8 words with no reads.
  - Exactly 16 acks, then full=1 and no further wr_en.
  - Drain of 16 matches the arbitration order: words 0-3 of producer 0, words 0-3 of producer 1, …

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port arbitration bus: producer request/ack lines plus the sync_fifo write side.
// The master modport is the arbiter; the slave modport is the producers/FIFO environment.
interface fifo_wr_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic                          fifo_full;
   logic [NUM_REQ-1:0]            ack;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic                          grant_valid;
   logic [ID_W-1:0]               grant_id;

   modport master (
      input  req, req_data, fifo_full,
      output ack, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
   );

   modport slave (
      output req, req_data, fifo_full,
      input  ack, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ producers,
// granting bounded bursts of up to MAX_BURST words and never writing into a full FIFO.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic              clk,
   input  logic              rst,
   fifo_wr_arbiter_if.master bus
);
   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {S_IDLE, S_GRANT} state_e;

   state_e           state_q,     state_d;
   logic [ID_W-1:0]  owner_q,     owner_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [ID_W-1:0]  rr_last_q,   rr_last_d;

   logic [ID_W-1:0]  base_c;
   logic [ID_W-1:0]  winner_c;
   logic             found_c;
   int unsigned      idx_c;
   logic             accept_c;
   logic             last_c;
   logic             release_c;

   // Search starts after the last owner; while granted the current owner is that last owner,
   // so it is scanned last and only wins when it is the sole requester.
   always_comb begin : winner_search
      base_c   = (state_q == S_GRANT) ? owner_q : rr_last_q;
      found_c  = 1'b0;
      winner_c = '0;
      idx_c    = 0;
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
         idx_c = 32'(base_c) + k;
         if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
         if (bus.req[ID_W'(idx_c)]) begin
            found_c  = 1'b1;
            winner_c = ID_W'(idx_c);
         end
      end
   end

   assign accept_c  = (state_q == S_GRANT) && bus.req[owner_q] && !bus.fifo_full;
   assign last_c    = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
   assign release_c = (state_q == S_GRANT) && ((accept_c && last_c) || !bus.req[owner_q]);

   assign bus.fifo_wr_en   = accept_c;
   assign bus.ack          = accept_c ? (NUM_REQ'(1) << owner_q) : '0;
   assign bus.fifo_wr_data = (state_q == S_GRANT) ?
                             bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign bus.grant_valid  = (state_q == S_GRANT);
   assign bus.grant_id     = owner_q;

   always_comb begin : next_state
      state_d     = state_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      rr_last_d   = rr_last_q;
      case (state_q)
         S_IDLE: begin
            if (found_c) begin
               state_d     = S_GRANT;
               owner_d     = winner_c;
               burst_cnt_d = '0;
            end
         end
         S_GRANT: begin
            if (release_c) begin
               rr_last_d = owner_q;
               if (found_c) begin
                  owner_d     = winner_c;
                  burst_cnt_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (accept_c) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin : state_reg
      if (!rst) begin
         state_q     <= S_IDLE;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         rr_last_q   <= ID_W'(NUM_REQ - 1);
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         rr_last_q   <= rr_last_d;
      end
   end
endmodule
